// File: rtl/lcd_spi_rx_if.sv
// ---------------------------------------------------------------------------
// lcd_spi_rx_if
//   Bundles the 4-wire LCD SPI pins and the receiver's decoded outputs.
//
//   Handshake rule for every strobe in this bundle (byte_valid, cmd_valid,
//   pix_valid, frame_done): the strobe is high for exactly one system clock
//   and its qualifying data fields are valid in that same cycle. There is no
//   ready/back-pressure path; the consumer must take the strobe when it is
//   presented. byte_data/byte_dc and cmd_code hold their value until the
//   next strobe of the same kind.
//
//   Modports:
//     master : the SPI driver side (drives spi_*, observes decoded outputs)
//     slave  : the receiver (samples spi_*, drives decoded outputs)
//
//   Signals:
//     spi_cs, spi_dc, spi_sclk, spi_mosi  SPI pins (cs active low, mode 0)
//     byte_valid/byte_data/byte_dc        raw byte stream with its dc tag
//     cmd_valid/cmd_code                  command byte strobe / last command
//     pix_valid/pix_x/pix_y/pix_data      RGB565 pixel writes with position
//     frame_done                          last pixel of the window written
//     err_cnt                             truncated-frame counter
//     dbg_state                           decoder FSM state, for observation
// ---------------------------------------------------------------------------
interface lcd_spi_rx_if #(
    parameter int X_W = 9,
    parameter int Y_W = 9
);
    logic           spi_cs;
    logic           spi_dc;
    logic           spi_sclk;
    logic           spi_mosi;

    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           byte_dc;
    logic           cmd_valid;
    logic [7:0]     cmd_code;
    logic           pix_valid;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic [15:0]    pix_data;
    logic           frame_done;
    logic [7:0]     err_cnt;
    logic [2:0]     dbg_state;

    modport master (
        output spi_cs, spi_dc, spi_sclk, spi_mosi,
        input  byte_valid, byte_data, byte_dc, cmd_valid, cmd_code,
        input  pix_valid, pix_x, pix_y, pix_data, frame_done, err_cnt,
        input  dbg_state
    );

    modport slave (
        input  spi_cs, spi_dc, spi_sclk, spi_mosi,
        output byte_valid, byte_data, byte_dc, cmd_valid, cmd_code,
        output pix_valid, pix_x, pix_y, pix_data, frame_done, err_cnt,
        output dbg_state
    );
endinterface

// File: rtl/lcd_spi_rx.sv
// ---------------------------------------------------------------------------
// lcd_spi_rx
//   Panel-side receiver for the 4-wire LCD SPI link. Oversamples the pins on
//   the system clock, assembles 8-bit frames tagged with dc, and decodes
//   CASET (0x2A), RASET (0x2B) and RAMWR (0x2C) into RGB565 pixel writes with
//   panel x/y coordinates.
//
//   Ports:
//     sys_clk_50MHz  system clock, at least 4x the SPI clock
//     sys_rst        asynchronous active-high reset
//     bus            lcd_spi_rx_if.slave (SPI pins in, decoded outputs out)
//
//   Build option:
//     LCD_SPI_RX_ERR_CNT_EN  when defined, err_cnt counts truncated frames
//                            (saturating at 255); otherwise err_cnt is 0.
// ---------------------------------------------------------------------------
module lcd_spi_rx #(
    parameter int X_W = 9,
    parameter int Y_W = 9
) (
    input  logic         sys_clk_50MHz,
    input  logic         sys_rst,
    lcd_spi_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CA_P     = 3'd1,
        ST_RA_P     = 3'd2,
        ST_RAMWR_HI = 3'd3,
        ST_RAMWR_LO = 3'd4,
        ST_OTHER    = 3'd5
    } dec_state_e;

    // ------------------------------------------------------------------
    // Input synchronizers. All four pins go through identical 2-FF chains
    // so dc/mosi stay aligned with the synchronized sclk edge.
    // cs resets high so no spurious frame is seen leaving reset.
    // ------------------------------------------------------------------
    logic [1:0] cs_sync_q;
    logic [1:0] dc_sync_q;
    logic [1:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_dly_q;

    always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
        if (sys_rst) begin
            cs_sync_q   <= 2'b11;
            dc_sync_q   <= 2'b00;
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            sclk_dly_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0],   bus.spi_cs};
            dc_sync_q   <= {dc_sync_q[0],   bus.spi_dc};
            sclk_sync_q <= {sclk_sync_q[0], bus.spi_sclk};
            mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
            sclk_dly_q  <= sclk_sync_q[1];
        end
    end

    logic cs_s;
    logic dc_s;
    logic mosi_s;
    logic sclk_rise;

    assign cs_s      = cs_sync_q[1];
    assign dc_s      = dc_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_sync_q[1] & ~sclk_dly_q;

    // ------------------------------------------------------------------
    // Shifter. Bits enter at the LSB so the first (MSB) bit ends on top.
    // byte_valid is registered, so it appears one clock after the 8th bit.
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       byte_valid_q;
    logic [7:0] byte_data_q;
    logic       byte_dc_q;

    always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
        if (sys_rst) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_dc_q    <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            if (cs_s) begin
                // Deselected: any partial byte is dropped here.
                bit_cnt_q <= 3'd0;
            end else if (sclk_rise) begin
                shift_q <= {shift_q[6:0], mosi_s};
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_q    <= 3'd0;
                    byte_data_q  <= {shift_q[6:0], mosi_s};
                    byte_dc_q    <= dc_s;
                    byte_valid_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Truncated-frame counter. The counter is only non-zero while cs is
    // low, so the first cycle of synchronized cs high with a non-zero
    // count is exactly one truncation event.
    // ------------------------------------------------------------------
`ifdef LCD_SPI_RX_ERR_CNT_EN
    logic       trunc;
    logic [7:0] err_cnt_q;

    assign trunc = cs_s & (bit_cnt_q != 3'd0);

    always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
        if (sys_rst) begin
            err_cnt_q <= 8'h00;
        end else if (trunc && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Decoder: state register
    // ------------------------------------------------------------------
    dec_state_e     state_q,      state_d;
    logic [1:0]     pidx_q,       pidx_d;
    logic [15:0]    par_s_q,      par_s_d;
    logic [7:0]     par_e_hi_q,   par_e_hi_d;
    logic [X_W-1:0] xs_q,         xs_d;
    logic [X_W-1:0] xe_q,         xe_d;
    logic [Y_W-1:0] ys_q,         ys_d;
    logic [Y_W-1:0] ye_q,         ye_d;
    logic [X_W-1:0] cur_x_q,      cur_x_d;
    logic [Y_W-1:0] cur_y_q,      cur_y_d;
    logic [7:0]     hi_q,         hi_d;
    logic [7:0]     cmd_code_q,   cmd_code_d;
    logic           cmd_valid_q,  cmd_valid_d;
    logic           pix_valid_q,  pix_valid_d;
    logic [X_W-1:0] pix_x_q,      pix_x_d;
    logic [Y_W-1:0] pix_y_q,      pix_y_d;
    logic [15:0]    pix_data_q,   pix_data_d;
    logic           frame_done_q, frame_done_d;

    always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            pidx_q       <= 2'd0;
            par_s_q      <= 16'h0000;
            par_e_hi_q   <= 8'h00;
            xs_q         <= '0;
            xe_q         <= X_W'(239);
            ys_q         <= '0;
            ye_q         <= Y_W'(239);
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            hi_q         <= 8'h00;
            cmd_code_q   <= 8'h00;
            cmd_valid_q  <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_data_q   <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pidx_q       <= pidx_d;
            par_s_q      <= par_s_d;
            par_e_hi_q   <= par_e_hi_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            hi_q         <= hi_d;
            cmd_code_q   <= cmd_code_d;
            cmd_valid_q  <= cmd_valid_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Decoder: next state and outputs
    // ------------------------------------------------------------------
    logic [15:0] par_word;
    assign par_word = {par_e_hi_q, byte_data_q};

    always_comb begin
        state_d      = state_q;
        pidx_d       = pidx_q;
        par_s_d      = par_s_q;
        par_e_hi_d   = par_e_hi_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        hi_d         = hi_q;
        cmd_code_d   = cmd_code_q;
        cmd_valid_d  = 1'b0;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;
        frame_done_d = 1'b0;

        if (byte_valid_q) begin
            if (!byte_dc_q) begin
                // Commands win in every state; a pending RAMWR high byte is
                // simply abandoned.
                cmd_code_d  = byte_data_q;
                cmd_valid_d = 1'b1;
                pidx_d      = 2'd0;
                case (byte_data_q)
                    8'h2A:   state_d = ST_CA_P;
                    8'h2B:   state_d = ST_RA_P;
                    8'h2C: begin
                        state_d = ST_RAMWR_HI;
                        cur_x_d = xs_q;
                        cur_y_d = ys_q;
                    end
                    default: state_d = ST_OTHER;
                endcase
            end else begin
                case (state_q)
                    ST_CA_P, ST_RA_P: begin
                        pidx_d = pidx_q + 2'd1;
                        case (pidx_q)
                            2'd0: par_s_d[15:8] = byte_data_q;
                            2'd1: par_s_d[7:0]  = byte_data_q;
                            2'd2: par_e_hi_d    = byte_data_q;
                            default: begin
                                // Window is only committed once all four
                                // parameter bytes have arrived.
                                if (state_q == ST_CA_P) begin
                                    xs_d = X_W'(par_s_q);
                                    xe_d = X_W'(par_word);
                                end else begin
                                    ys_d = Y_W'(par_s_q);
                                    ye_d = Y_W'(par_word);
                                end
                                pidx_d  = 2'd0;
                                state_d = ST_IDLE;
                            end
                        endcase
                    end
                    ST_RAMWR_HI: begin
                        hi_d    = byte_data_q;
                        state_d = ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        pix_valid_d  = 1'b1;
                        pix_data_d   = {hi_q, byte_data_q};
                        pix_x_d      = cur_x_q;
                        pix_y_d      = cur_y_q;
                        frame_done_d = (cur_x_q == xe_q) && (cur_y_q == ye_q);
                        // Equality-based advance: an inverted window (xs>xe)
                        // wraps through 2^X_W until it meets xe.
                        if (cur_x_q == xe_q) begin
                            cur_x_d = xs_q;
                            cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + Y_W'(1);
                        end else begin
                            cur_x_d = cur_x_q + X_W'(1);
                        end
                        state_d = ST_RAMWR_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.byte_dc    = byte_dc_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_code   = cmd_code_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_data   = pix_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// ---------------------------------------------------------------------------
// tb_lcd_spi_rx
//   Directed bench for lcd_spi_rx: drives SPI frames at sclk = clk/8 and
//   checks the byte, command and pixel streams against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lcd_spi_rx;
  localparam int X_W = 9;
  localparam int Y_W = 9;
`ifdef LCD_SPI_RX_ERR_CNT_EN
  localparam logic [7:0] EXP_ERR = 8'd1;
`else
  localparam logic [7:0] EXP_ERR = 8'd0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  lcd_spi_rx_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  lcd_spi_rx #(.X_W(X_W), .Y_W(Y_W)) dut (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst),
    .bus           (bus.slave)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- monitor (observed streams) ----------------
  logic [34:0] pix_obs[$];   // {frame_done, x, y, data}
  logic [8:0]  byte_obs[$];  // {dc, data}
  logic [7:0]  cmd_obs[$];
  int viol = 0;
  logic pv_prev = 1'b0, cv_prev = 1'b0, bv_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pix_valid) pix_obs.push_back({bus.frame_done, bus.pix_x, bus.pix_y, bus.pix_data});
      if (bus.byte_valid) byte_obs.push_back({bus.byte_dc, bus.byte_data});
      if (bus.cmd_valid) cmd_obs.push_back(bus.cmd_code);
      if (bus.frame_done && !bus.pix_valid) viol++;
      if (bus.pix_valid && bus.cmd_valid) viol++;
      if ((pv_prev && bus.pix_valid) || (cv_prev && bus.cmd_valid) || (bv_prev && bus.byte_valid)) viol++;
    end
    pv_prev = bus.pix_valid;
    cv_prev = bus.cmd_valid;
    bv_prev = bus.byte_valid;
  end

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_pix(input logic fd, input int x, input int y, input logic [15:0] d);
    exp_q.push_back({fd, X_W'(x), Y_W'(y), d});
  endtask

  task automatic check_pix(input string tag);
    logic [34:0] e;
    logic [34:0] o;
    chk({tag, "_count"}, 64'(pix_obs.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (pix_obs.size() > 0) ? pix_obs.pop_front() : '1;
      chk(tag, 64'(o), 64'(e));
    end
    pix_obs.delete();
  endtask

  task automatic clear_obs();
    pix_obs.delete();
    byte_obs.delete();
    cmd_obs.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_byte_valid"}, 64'(bus.byte_valid), 64'd0);
    chk({tag, "_byte_data"},  64'(bus.byte_data),  64'd0);
    chk({tag, "_byte_dc"},    64'(bus.byte_dc),    64'd0);
    chk({tag, "_cmd_valid"},  64'(bus.cmd_valid),  64'd0);
    chk({tag, "_cmd_code"},   64'(bus.cmd_code),   64'd0);
    chk({tag, "_pix_valid"},  64'(bus.pix_valid),  64'd0);
    chk({tag, "_pix_x"},      64'(bus.pix_x),      64'd0);
    chk({tag, "_pix_y"},      64'(bus.pix_y),      64'd0);
    chk({tag, "_pix_data"},   64'(bus.pix_data),   64'd0);
    chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
    chk({tag, "_err_cnt"},    64'(bus.err_cnt),    64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bits(input logic dc, input logic [7:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_dc   = dc;
      bus.spi_mosi = data[7-i];
      repeat (4) @(negedge clk);
      bus.spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] data);
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(dc, data, 8);
    repeat (4) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] caset_p [4] = '{8'h00, 8'h0A, 8'h00, 8'h0B};
  logic [7:0] raset_p [4] = '{8'h00, 8'h14, 8'h00, 8'h15};
  logic [7:0] fill_d  [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
  logic [7:0] wrap_d  [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] post_d  [4] = '{8'h00, 8'h11, 8'h22, 8'h33};

  initial begin
    rst          = 1'b1;
    bus.spi_cs   = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_dc   = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Byte path
    clear_obs();
    send_byte(1'b0, 8'h2A);
    chk("byte_count",   64'(byte_obs.size()), 64'd1);
    chk("byte_word",    64'(byte_obs[0]),     64'h02A);
    chk("byte_data",    64'(bus.byte_data),   64'h2A);
    chk("byte_dc",      64'(bus.byte_dc),     64'd0);
    chk("cmd_count",    64'(cmd_obs.size()),  64'd1);
    chk("cmd_strobe",   64'(cmd_obs[0]),      64'h2A);
    chk("cmd_code",     64'(bus.cmd_code),    64'h2A);

    // Window fill
    for (int i = 0; i < 4; i++) send_byte(1'b1, caset_p[i]);
    send_byte(1'b0, 8'h2B);
    for (int i = 0; i < 4; i++) send_byte(1'b1, raset_p[i]);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 8; i++) send_byte(1'b1, fill_d[i]);
    chk("fill_byte_dc", 64'(bus.byte_dc),    64'd1);
    chk("fill_cmds",    64'(cmd_obs.size()), 64'd3);
    exp_pix(1'b0, 10, 20, 16'hF800);
    exp_pix(1'b0, 11, 20, 16'h07E0);
    exp_pix(1'b0, 10, 21, 16'h001F);
    exp_pix(1'b1, 11, 21, 16'hFFFF);
    check_pix("fill_pix");

    // Wrap back to window origin
    for (int i = 0; i < 4; i++) send_byte(1'b1, wrap_d[i]);
    exp_pix(1'b0, 10, 20, 16'h1234);
    exp_pix(1'b0, 11, 20, 16'h5678);
    check_pix("wrap_pix");

    // Truncation: 5 bits then cs high
    clear_obs();
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(1'b1, 8'hFF, 5);
    repeat (4) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("trunc_no_strobe", 64'(byte_obs.size()), 64'd0);
    chk("trunc_err_cnt",   64'(bus.err_cnt),     64'(EXP_ERR));
    send_byte(1'b0, 8'h2C);
    chk("trunc_byte_count", 64'(byte_obs.size()), 64'd1);
    chk("trunc_cmd_code",   64'(bus.cmd_code),    64'h2C);
    send_byte(1'b1, 8'hAB);
    send_byte(1'b1, 8'hCD);
    exp_pix(1'b0, 10, 20, 16'hABCD);
    check_pix("trunc_pix");

    // Interrupted pixel
    clear_obs();
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12);
    send_byte(1'b0, 8'h00);
    chk("intr_no_pix",   64'(pix_obs.size()),  64'd0);
    chk("intr_cmds",     64'(cmd_obs.size()),  64'd2);
    chk("intr_last_cmd", 64'(cmd_obs[1]),      64'h00);
    chk("intr_cmd_code", 64'(bus.cmd_code),    64'h00);

    // Reset mid-byte
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(1'b1, 8'hA5, 3);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("mid_reset");
    bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clear_obs();
    send_byte(1'b0, 8'h2C);
    chk("post_rst_cmd",  64'(bus.cmd_code), 64'h2C);
    chk("post_rst_err",  64'(bus.err_cnt),  64'd0);
    for (int i = 0; i < 4; i++) send_byte(1'b1, post_d[i]);
    exp_pix(1'b0, 0, 0, 16'h0011);
    exp_pix(1'b0, 1, 0, 16'h2233);
    check_pix("post_rst_pix");

    chk("strobe_rules", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_spi_rx.md
Name: lcd_spi_rx

Overview:
- Panel-side receiver for the 4-wire LCD SPI link (cs, dc, sclk, mosi) driven by the display write path.
- Oversamples the SPI pins on the system clock and assembles 8-bit frames, each tagged with its dc bit.
- Decodes CASET/RASET/RAMWR and emits RGB565 pixel writes with panel x/y coordinates, ready to feed a frame-buffer model or a capture checker.
- Serves as the verification sink for the display path, and is also synthesizable for on-chip loopback.

Parameters:
- X_W, 9, width of column coordinate.
- Y_W, 9, width of row coordinate.

Ports:
- sys_clk_50MHz  in  1  system clock; must be at least 4x the sclk frequency.
- sys_rst  in  1  asynchronous, active-high reset.
- spi_cs  in  1  chip select, active low, asynchronous to sys_clk_50MHz.
- spi_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- spi_sclk  in  1  SPI clock, mode 0 (sample on rising edge).
- spi_mosi  in  1  serial data, MSB first.
- byte_valid  out  1  one-cycle strobe: a complete byte has been received.
- byte_data  out  8  received byte; held until the next strobe.
- byte_dc  out  1  dc bit of byte_data.
- cmd_valid  out  1  one-cycle strobe on every command byte (dc=0).
- cmd_code  out  8  last command byte received.
- pix_valid  out  1  one-cycle strobe: a pixel has been written.
- pix_x  out  X_W  column of the pixel.
- pix_y  out  Y_W  row of the pixel.
- pix_data  out  16  RGB565 pixel value, first byte in [15:8].
- frame_done  out  1  one-cycle strobe when pixel (xe,ye) of the window is written.
- err_cnt  out  8  count of truncated frames (see Optional Feature).

Behaviour:
- Input sync: cs, dc, sclk and mosi each pass through 2-FF synchronizers. Rising sclk edge detected from the synchronized copy plus one delay FF. Total detection latency 3 clocks.
- Reset (async, sys_rst=1): all outputs 0; cmd_code=0x00; window xs=0, xe=239, ys=0, ye=239; bit counter 0; decoder state IDLE.
- Shifter:
  - While cs is high, the bit counter is held at 0 and no bits are captured.
  - On each sclk rising edge with cs low: shift mosi in LSB-first into the register (first bit ends up as MSB).
  - On the 8th bit: latch dc, pulse byte_valid 1 clock later, reset the counter.
- Truncation: cs rising with counter != 0 discards the partial byte and produces no strobe. Decoder state is kept across cs toggles.
- Decoder FSM states: IDLE, CA_P (column params), RA_P (row params), RAMWR_HI, RAMWR_LO, OTHER.
  - Any command byte, in any state: update cmd_code, pulse cmd_valid, reset the param index to 0. Then:
    - 0x2A -> CA_P.
    - 0x2B -> RA_P.
    - 0x2C -> RAMWR_HI, with cursor x=xs, y=ys.
    - anything else -> OTHER.
  - CA_P, params 0..3 = XS[15:8], XS[7:0], XE[15:8], XE[7:0]. Values are truncated to X_W bits and committed when param 3 arrives; then -> IDLE. Fewer than 4 params leaves the window unchanged.
  - RA_P: same as CA_P but for ys/ye, truncated to Y_W bits.
  - RAMWR_HI: data byte -> latch high byte, go to RAMWR_LO.
  - RAMWR_LO: data byte -> pix_valid with pix_data={hi,lo}, pix_x/pix_y = current cursor; go to RAMWR_HI.
  - OTHER and IDLE: data bytes are ignored.
- Cursor advance after each pixel:
  - if x==xe: x=xs, then y = (y==ye) ? ys : y+1;
  - else x=x+1.
  - frame_done pulses in the same cycle as pix_valid when (x,y)==(xe,ye).
- Degenerate windows:
  - xs>xe: x increments until it equals xe modulo 2^X_W, i.e. it wraps naturally.
  - xs==xe: single-column window.
  - The same rules apply to y.
- A command arriving during RAMWR_LO drops the pending high byte; no pixel is emitted.
- cmd_valid, pix_valid and byte_valid never last longer than one cycle. cmd_valid and pix_valid are mutually exclusive.

Optional Feature:
- Macro LCD_SPI_RX_ERR_CNT_EN.
- Defined: err_cnt increments on every truncated frame (cs rising with counter != 0), saturates at 255, and is cleared by reset.
- Undefined: no counter logic is built and err_cnt is tied to 0.

Test Plan:
- Byte path: send command 0x2A with dc=0 at sclk = clk/8 -> one byte_valid with byte_data=0x2A, byte_dc=0; cmd_valid=1, cmd_code=0x2A.
- Window fill:
  - Stimulus: CASET 00 0A 00 0B, RASET 00 14 00 15, RAMWR, then 8 bytes F8 00 07 E0 00 1F FF FF.
  - Required: 4 pixels at (10,20)=F800, (11,20)=07E0, (10,21)=001F, (11,21)=FFFF.
  - frame_done pulses on the 4th pixel only.
- Wrap: continue with 2 more pixels after the window fill -> (10,20) and (11,20); no frame_done.
- Truncation:
  - Drop cs after 5 bits, then send a full byte 0x2C -> no strobe for the partial byte.
  - 0x2C is decoded correctly.
  - err_cnt=1 with macro defined, 0 without.
- Interrupted pixel: RAMWR, data 0x12, then command 0x00 -> no pix_valid; cmd_valid with cmd_code=0x00.
- Reset mid-byte: assert sys_rst after 3 bits, release, send 0x2C -> all outputs 0 during reset; clean decode afterwards; window restored to default 0..239.
